// File: rtl/ldtu_bsl_estimator.sv
// Baseline estimator: averages 2^LOG2_NS accepted pedestal samples into a clamped 8-bit BSL_VAL.
// Define BSL_ROUND_EN to round the mean half up instead of truncating it.
module ldtu_bsl_estimator #(
  parameter int unsigned          Nbits_12 = 12,
  parameter int unsigned          Nbits_8  = 8,
  parameter int unsigned          LOG2_NS  = 4,
  parameter logic [Nbits_12-1:0]  THR      = 12'd1023,
  parameter int unsigned          TIMEOUT  = 1024
) (
  input  logic                DCLK,
  input  logic                rst,
  input  logic [Nbits_12-1:0] DATA12,
  input  logic                start,
  output logic [Nbits_8-1:0]  BSL_VAL,
  output logic                bsl_valid,
  output logic                busy,
  output logic                sat,
  output logic                err
);

  localparam int unsigned AccW  = Nbits_12 + LOG2_NS;
  localparam int unsigned CntW  = LOG2_NS + 1;
  localparam int unsigned CycW  = $clog2(TIMEOUT + 1);
  localparam int unsigned MeanW = Nbits_12 + 1;

  localparam logic [CntW-1:0]  NumSamples = CntW'(2 ** LOG2_NS);
  localparam logic [CycW-1:0]  TimeoutCnt = CycW'(TIMEOUT);
  localparam logic [MeanW-1:0] MaxMean    = MeanW'((2 ** Nbits_8) - 1);

  typedef enum logic [1:0] {StIdle, StAccum, StCalc} state_e;

  state_e               state_q, state_d;
  logic [AccW-1:0]      acc_q, acc_d;
  logic [CntW-1:0]      acc_cnt_q, acc_cnt_d;
  logic [CycW-1:0]      cyc_cnt_q, cyc_cnt_d;
  logic [Nbits_8-1:0]   bsl_q, bsl_d;
  logic                 valid_q, valid_d;
  logic                 sat_q, sat_d;
  logic                 err_q, err_d;

  logic                 accept;
  logic [CntW-1:0]      acc_cnt_inc;
  logic [CycW-1:0]      cyc_cnt_inc;
  logic                 last_accept;
  logic                 timeout_hit;
  logic [MeanW-1:0]     mean;
  logic                 mean_sat;

  assign accept      = (DATA12 <= THR);
  assign acc_cnt_inc = acc_cnt_q + CntW'(1);
  assign cyc_cnt_inc = cyc_cnt_q + CycW'(1);
  assign last_accept = accept && (acc_cnt_inc == NumSamples);
  assign timeout_hit = (cyc_cnt_inc == TimeoutCnt);

`ifdef BSL_ROUND_EN
  localparam int unsigned RndW = AccW + 1;
  logic [RndW-1:0] acc_rnd;
  assign acc_rnd = {1'b0, acc_q} + RndW'(2 ** (LOG2_NS - 1));
  assign mean    = acc_rnd[RndW-1:LOG2_NS];
`else
  assign mean    = {1'b0, acc_q[AccW-1:LOG2_NS]};
`endif

  assign mean_sat = (mean > MaxMean);

  always_ff @(posedge DCLK) begin
    if (rst) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      acc_cnt_q <= '0;
      cyc_cnt_q <= '0;
      bsl_q     <= '0;
      valid_q   <= 1'b0;
      sat_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      acc_cnt_q <= acc_cnt_d;
      cyc_cnt_q <= cyc_cnt_d;
      bsl_q     <= bsl_d;
      valid_q   <= valid_d;
      sat_q     <= sat_d;
      err_q     <= err_d;
    end
  end

  // Completion is tested before timeout so a final accept on the timeout edge still succeeds.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StAccum;
      StAccum: begin
        if (last_accept)      state_d = StCalc;
        else if (timeout_hit) state_d = StIdle;
      end
      StCalc:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    acc_d     = acc_q;
    acc_cnt_d = acc_cnt_q;
    cyc_cnt_d = cyc_cnt_q;
    bsl_d     = bsl_q;
    valid_d   = 1'b0;
    sat_d     = sat_q;
    err_d     = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d     = '0;
          acc_cnt_d = '0;
          cyc_cnt_d = '0;
          sat_d     = 1'b0;
          err_d     = 1'b0;
        end
      end
      StAccum: begin
        cyc_cnt_d = cyc_cnt_inc;
        if (accept) begin
          acc_d     = acc_q + AccW'(DATA12);
          acc_cnt_d = acc_cnt_inc;
        end
        if (!last_accept && timeout_hit) err_d = 1'b1;
      end
      StCalc: begin
        bsl_d   = mean_sat ? '1 : mean[Nbits_8-1:0];
        sat_d   = mean_sat;
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy      = (state_q == StAccum) || (state_q == StCalc);
    BSL_VAL   = bsl_q;
    bsl_valid = valid_q;
    sat       = sat_q;
    err       = err_q;
  end

endmodule

// File: tb/tb_ldtu_bsl_estimator.sv
// Self-checking bench for ldtu_bsl_estimator against a run-level reference model.
module tb_ldtu_bsl_estimator;

  localparam int Thr     = 1023;
  localparam int Timeout = 32;
  localparam int Ns      = 16;
`ifdef BSL_ROUND_EN
  localparam int Rnd = Ns / 2;
`else
  localparam int Rnd = 0;
`endif

  logic        DCLK = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] DATA12 = '0;
  logic        start = 1'b0;
  logic [7:0]  BSL_VAL;
  logic        bsl_valid, busy, sat, err;

  int n_vec = 0;
  int n_err = 0;
  int samp[64];
  int restart_at = -1;
  int rst_at = -1;
  int model_bsl = 0;

  ldtu_bsl_estimator #(
    .Nbits_12 (12),
    .Nbits_8  (8),
    .LOG2_NS  (4),
    .THR      (12'd1023),
    .TIMEOUT  (Timeout)
  ) dut (
    .DCLK      (DCLK),
    .rst       (rst),
    .DATA12    (DATA12),
    .start     (start),
    .BSL_VAL   (BSL_VAL),
    .bsl_valid (bsl_valid),
    .busy      (busy),
    .sat       (sat),
    .err       (err)
  );

  always #5 DCLK = ~DCLK;

  // Runs one calibration request: i indexes edges E0.., outputs checked after each edge.
  task automatic run_case(input string name, input int tl);
    int acc, cnt, mode, ev, mean, last;
    int new_val, old_val;
    bit new_sat;
    logic e_busy, e_valid, e_sat, e_err;
    logic [7:0] e_bsl;
    acc = 0; cnt = 0; mode = 1; ev = Timeout;
    for (int e = 1; e <= Timeout; e++) begin
      if (rst_at > 0 && e == rst_at) begin mode = 2; ev = e; break; end
      if (samp[e-1] <= Thr) begin acc += samp[e-1]; cnt++; end
      if (cnt == Ns) begin mode = 0; ev = e; break; end
    end
    mean    = (acc + Rnd) / Ns;
    new_sat = (mean > 255);
    new_val = new_sat ? 255 : mean;
    old_val = model_bsl;
    last    = (mode == 0) ? ev + 1 : ev;
    for (int i = 0; i <= last + tl; i++) begin
      rst    = (rst_at > 0 && i == rst_at);
      start  = (i == 0) || (i == restart_at);
      DATA12 = (i > 0) ? 12'(samp[i-1]) : 12'(i);
      @(negedge DCLK);
      case (mode)
        0: begin
          e_busy = (i <= ev); e_valid = (i == ev + 1);
          e_bsl = 8'((i > ev) ? new_val : old_val);
          e_sat = (i > ev) ? new_sat : 1'b0; e_err = 1'b0;
        end
        1: begin
          e_busy = (i < ev); e_valid = 1'b0; e_bsl = 8'(old_val);
          e_sat = 1'b0; e_err = (i >= ev);
        end
        default: begin
          e_busy = (i < ev); e_valid = 1'b0;
          e_bsl = 8'((i >= ev) ? 0 : old_val); e_sat = 1'b0; e_err = 1'b0;
        end
      endcase
      n_vec += 5;
      if (busy !== e_busy) begin
        n_err++; $display("FAIL %s busy E%0d: got %b want %b", name, i, busy, e_busy);
      end
      if (bsl_valid !== e_valid) begin
        n_err++; $display("FAIL %s bsl_valid E%0d: got %b want %b", name, i, bsl_valid, e_valid);
      end
      if (BSL_VAL !== e_bsl) begin
        n_err++; $display("FAIL %s BSL_VAL E%0d: got %0d want %0d", name, i, BSL_VAL, e_bsl);
      end
      if (sat !== e_sat) begin
        n_err++; $display("FAIL %s sat E%0d: got %b want %b", name, i, sat, e_sat);
      end
      if (err !== e_err) begin
        n_err++; $display("FAIL %s err E%0d: got %b want %b", name, i, err, e_err);
      end
    end
    rst   = 1'b0;
    start = 1'b0;
    if (mode == 0) model_bsl = new_val;
    else if (mode == 2) model_bsl = 0;
    restart_at = -1;
    rst_at     = -1;
  endtask

  task automatic fill_const(input int v);
    for (int k = 0; k < 64; k++) samp[k] = v;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; DATA12 = 12'd100;
    repeat (3) @(negedge DCLK);
    n_vec += 5;
    if (BSL_VAL !== 8'd0) begin n_err++; $display("FAIL reset BSL_VAL: got %0d want 0", BSL_VAL); end
    if (bsl_valid !== 1'b0) begin n_err++; $display("FAIL reset bsl_valid: got %b want 0", bsl_valid); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b want 0", busy); end
    if (sat !== 1'b0) begin n_err++; $display("FAIL reset sat: got %b want 0", sat); end
    if (err !== 1'b0) begin n_err++; $display("FAIL reset err: got %b want 0", err); end
    rst = 1'b0; start = 1'b0;
    @(negedge DCLK);
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset idle busy: got %b want 0", busy); end
    model_bsl = 0;
  endtask

  task automatic test_constant();
    fill_const(100);
    run_case("constant100", 1);
  endtask

  task automatic test_alternate();
    for (int k = 0; k < 64; k++) samp[k] = (k % 2) ? 101 : 100;
    run_case("alternate", 1);
  endtask

  task automatic test_reject();
    fill_const(50);
    samp[1] = 4000; samp[6] = 4000; samp[10] = 4000;
    run_case("reject3", 1);
  endtask

  task automatic test_saturate();
    fill_const(600);
    run_case("saturate", 1);
  endtask

  task automatic test_timeout();
    fill_const(2000);
    run_case("timeout", 1);
    fill_const(50);
    run_case("err_clear", 1);
  endtask

  task automatic test_restart_ignored();
    fill_const(100);
    restart_at = 5;
    run_case("restart_ignored", 1);
  endtask

  task automatic test_reset_mid();
    fill_const(100);
    rst_at = 8;
    run_case("reset_mid", 1);
  endtask

  task automatic test_back_to_back();
    fill_const(77);
    run_case("b2b_a", 0);
    fill_const(200);
    samp[15] = 3000;
    run_case("b2b_b", 0);
    fill_const(2000);
    run_case("b2b_to", 0);
    fill_const(5);
    run_case("b2b_c", 1);
  endtask

  task automatic test_random();
    int vmax, rej;
    for (int r = 0; r < 24; r++) begin
      vmax = (r % 2) ? 1023 : 300;
      rej  = (r % 6 == 5) ? 1 : 7;
      for (int k = 0; k < 64; k++) begin
        if ($urandom_range(0, rej) == 0) samp[k] = int'($urandom_range(1024, 4095));
        else samp[k] = int'($urandom_range(0, vmax));
      end
      if (r % 4 == 3) restart_at = int'($urandom_range(1, 15));
      run_case("random", int'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_alternate();
    test_reject();
    test_saturate();
    test_timeout();
    test_restart_ignored();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
